fpu_normalize_pipe: RTL

- Two-stage pipelined post-add normalizer for the single-precision FPU datapath.
- Sits directly upstream of the rounding stage.
- Takes the raw adder/subtractor mantissa (carry bit plus hidden/fraction/guard/round/sticky/extend) and its tentative exponent.
- Produces a normalized 28-bit mantissa, with hidden bit at MSB, and an adjusted exponent with status flags, under valid/ready flow control.

---
 rtl/fpu_pkg.sv | 18 +
 rtl/fpu_lzc.sv | 24 ++
 rtl/fpu_normalize_pipe.sv | 122 ++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU widths and normalizer stage-1 record
package fpu_pkg;

  localparam int SIZE_MANTISSA = 28;
  localparam int SIZE_EXPONENT = 8;
  localparam int SIZE_LZC      = 5;
  localparam logic [SIZE_EXPONENT-1:0] EXP_INF = '1;

  typedef struct packed {
    logic                     sign;
    logic [SIZE_EXPONENT-1:0] exponent;
    logic [SIZE_MANTISSA:0]   mantissa_raw;
    logic                     carry;
    logic                     zero;
    logic [SIZE_LZC-1:0]      lz;
  } norm_s1_t;

endpackage

// File: rtl/fpu_lzc.sv
// rtl/fpu_lzc.sv - combinational leading-zero counter
module fpu_lzc #(
  parameter int WIDTH = 28,
  parameter int LZC_W = 5
) (
  input  logic [WIDTH-1:0] data,
  output logic [LZC_W-1:0] count
);

  logic found;

  // Scan from the MSB; the first set bit fixes the count, all-zero yields WIDTH.
  always_comb begin
    count = LZC_W'(WIDTH);
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && data[i]) begin
        found = 1'b1;
        count = LZC_W'(WIDTH - 1 - i);
      end
    end
  end

endmodule

// File: rtl/fpu_normalize_pipe.sv
// rtl/fpu_normalize_pipe.sv - two-stage post-add mantissa normalizer
module fpu_normalize_pipe
  import fpu_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic                     i_sign,
  input  logic [SIZE_EXPONENT-1:0] i_exponent,
  input  logic [SIZE_MANTISSA:0]   i_mantissa_raw,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_sign,
  output logic [SIZE_EXPONENT-1:0] o_exponent,
  output logic [SIZE_MANTISSA-1:0] o_mantissa,
  output logic                     o_zero,
  output logic                     o_overflow,
  output logic                     o_underflow
);

  logic                     s1_valid;
  norm_s1_t                 s1;
  logic                     s1_en;
  logic                     s2_en;
  logic [SIZE_LZC-1:0]      lz;

  logic [SIZE_EXPONENT:0]   exp_inc;
  logic [SIZE_EXPONENT-1:0] lz_ext;
  logic [SIZE_MANTISSA-1:0] shifted;
  logic [SIZE_EXPONENT-1:0] n_exponent;
  logic [SIZE_MANTISSA-1:0] n_mantissa;
  logic                     n_zero;
  logic                     n_overflow;
  logic                     n_underflow;

  // A stage may load when it is empty or its contents are leaving this cycle.
  assign s2_en   = ~o_valid | i_ready;
  assign s1_en   = ~s1_valid | s2_en;
  assign o_ready = s1_en;

  fpu_lzc #(
    .WIDTH (SIZE_MANTISSA),
    .LZC_W (SIZE_LZC)
  ) u_lzc (
    .data  (i_mantissa_raw[SIZE_MANTISSA-1:0]),
    .count (lz)
  );

  // Stage 1: capture the beat and classify it (carry, zero, leading zeros).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (s1_en) begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1.sign         <= i_sign;
        s1.exponent     <= i_exponent;
        s1.mantissa_raw <= i_mantissa_raw;
        s1.carry        <= i_mantissa_raw[SIZE_MANTISSA];
        s1.zero         <= (i_mantissa_raw == '0);
        s1.lz           <= lz;
      end
    end
  end

  assign exp_inc = {1'b0, s1.exponent} + (SIZE_EXPONENT+1)'(1);
  assign lz_ext  = {{(SIZE_EXPONENT-SIZE_LZC){1'b0}}, s1.lz};
  assign shifted = s1.mantissa_raw[SIZE_MANTISSA-1:0] << s1.lz;

  // Normalization decision, priority zero > carry > left shift / underflow.
  always_comb begin
    n_exponent  = '0;
    n_mantissa  = '0;
    n_zero      = 1'b0;
    n_overflow  = 1'b0;
    n_underflow = 1'b0;
    if (s1.zero) begin
      n_zero = 1'b1;
    end else if (s1.carry) begin
      if (exp_inc >= {1'b0, EXP_INF}) begin
        n_overflow = 1'b1;
        n_exponent = EXP_INF;
      end else begin
        n_exponent = exp_inc[SIZE_EXPONENT-1:0];
        // Right shift by one; the dropped LSB folds into sticky.
        n_mantissa = s1.mantissa_raw[SIZE_MANTISSA:1]
                   | {{(SIZE_MANTISSA-1){1'b0}}, s1.mantissa_raw[0]};
      end
    end else if (lz_ext < s1.exponent) begin
      n_mantissa = shifted;
      n_exponent = s1.exponent - lz_ext;
    end else begin
      n_underflow = 1'b1;
    end
  end

  // Stage 2: registered outputs, held while the rounding stage stalls.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid     <= 1'b0;
      o_sign      <= 1'b0;
      o_exponent  <= '0;
      o_mantissa  <= '0;
      o_zero      <= 1'b0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else if (s2_en) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_sign      <= s1.sign;
        o_exponent  <= n_exponent;
        o_mantissa  <= n_mantissa;
        o_zero      <= n_zero;
        o_overflow  <= n_overflow;
        o_underflow <= n_underflow;
      end
    end
  end

endmodule
